// File: rtl/mem_ctrl.sv
// Memory-stage controller: decodes loads/stores, runs one request/ack bus
// transaction per access with an ack timeout, and forms the writeback result.
module mem_ctrl #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_req,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        exc_align,
  output logic        bus_err
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        sign_ext;
  size_t       size;
  logic        misaligned;
  logic [3:0]  sel_calc;
  logic [31:0] store_data;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_result;
  logic        timeout_hit;

  // Operation decode; opcodes 9-15 fall through as no memory access.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SZ_WORD;
    case (mem_op)
      OP_LB:   begin is_load  = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_HALF; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_WORD; end
      OP_SB:   begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:   begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:   begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = is_mem &&
                      (((size == SZ_HALF) && mem_addr[0]) ||
                       ((size == SZ_WORD) && (mem_addr[1:0] != 2'b00)));

  // Byte lanes are big-endian: the lowest byte address sits in bits [31:24].
  always_comb begin
    sel_calc   = 4'b1111;
    store_data = mem_sdata;
    case (size)
      SZ_BYTE: begin
        sel_calc   = 4'b1000 >> mem_addr[1:0];
        store_data = {4{mem_sdata[7:0]}};
      end
      SZ_HALF: begin
        sel_calc   = mem_addr[1] ? 4'b0011 : 4'b1100;
        store_data = {2{mem_sdata[15:0]}};
      end
      default: ;
    endcase
    if (!is_store) store_data = 32'h0;
  end

  always_comb begin
    byte_val = bus_rdata[31:24];
    case (mem_addr[1:0])
      2'd0:    byte_val = bus_rdata[31:24];
      2'd1:    byte_val = bus_rdata[23:16];
      2'd2:    byte_val = bus_rdata[15:8];
      default: byte_val = bus_rdata[7:0];
    endcase
    half_val = mem_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (size)
      SZ_BYTE: load_result = sign_ext ? {{24{byte_val[7]}}, byte_val} : {24'h0, byte_val};
      SZ_HALF: load_result = sign_ext ? {{16{half_val[15]}}, half_val} : {16'h0, half_val};
      default: load_result = bus_rdata;
    endcase
  end

  assign timeout_hit = (state == BUS) && !bus_ack && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // The final timeout cycle releases the stall so upstream can advance.
  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem && !misaligned) begin
          stall_req  = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (bus_ack || timeout_hit) state_next = IDLE;
        else                        stall_req  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_sel   <= 4'h0;
      bus_wdata <= 32'h0;
      wb_wd     <= 5'h0;
      wb_wreg   <= 1'b0;
      wb_wdata  <= 32'h0;
      exc_align <= 1'b0;
      bus_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      exc_align <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
          end else if (misaligned) begin
            exc_align <= 1'b1;
            wb_wd     <= 5'h0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= 32'h0;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= sel_calc;
            bus_wdata <= store_data;
            wait_cnt  <= '0;
            wb_wd     <= 5'h0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= 32'h0;
          end
        end
        BUS: begin
          if (bus_ack || timeout_hit) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_sel   <= 4'h0;
            bus_wdata <= 32'h0;
          end
          if (bus_ack) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= is_load ? load_result : mem_wdata;
          end else if (timeout_hit) begin
            bus_err  <= 1'b1;
            wb_wd    <= 5'h0;
            wb_wreg  <= 1'b0;
            wb_wdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            wb_wreg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: per-feature tasks push expected writeback
// records, drive one access with a scripted bus responder, then pop and compare.
module tb_mem_ctrl;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_req;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        exc_align;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        exc;
    logic        err;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } busv_t;

  typedef struct {
    wb_t   wb;
    int    stalls;
    int    reqs;
    busv_t bus;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
    logic [31:0] res;
    logic [3:0]  sel;
  } case_t;

  exp_t sb[$];

  mem_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .stall_req (stall_req),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .exc_align (exc_align),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and plays the bus slave until stall_req drops.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] wdata,
                        input logic [4:0] wd, input logic wreg,
                        input logic [31:0] rdata, input int ack_delay, input bit trail,
                        output int stalls, output int reqs, output busv_t snap,
                        output wb_t fin, output logic [1:0] after,
                        output bit hung, output bit varied);
    int    waits;
    bit    st;
    busv_t cur;
    stalls = 0; reqs = 0; snap = '0; waits = 0; hung = 1'b1; varied = 1'b0; after = 2'b00;
    mem_op = op; mem_addr = addr; mem_sdata = sdata; mem_wdata = wdata;
    mem_wd = wd; mem_wreg = wreg; bus_rdata = rdata;
    for (int c = 0; c < 64; c++) begin
      bus_ack = 1'b0;
      if (bus_req) begin
        cur = '{bus_we, bus_addr, bus_sel, bus_wdata};
        if (reqs == 0) snap = cur;
        else if (cur !== snap) varied = 1'b1;
        reqs++;
        if (waits == ack_delay) bus_ack = 1'b1;
        else waits++;
      end
      #1 st = stall_req;
      if (st) stalls++;
      step();
      bus_ack = 1'b0;
      if (!st) begin
        hung = 1'b0;
        break;
      end
    end
    fin = '{wb_wd, wb_wreg, wb_wdata, exc_align, bus_err};
    if (trail) begin
      mem_op = 4'd0; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
      step();
      after = {exc_align, bus_err};
    end
  endtask

  task automatic test_reset();
    logic [146:0] outs;
    rst = 1'b1;
    #2 rst = 1'b0;
    step();
    step();
    outs = {bus_req, bus_we, bus_addr, bus_sel, bus_wdata, wb_wd, wb_wreg,
            wb_wdata, exc_align, bus_err, stall_req, 36'h0};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h want 0", outs);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu_pass();
    case_t tbl[3];
    int stalls, reqs; busv_t snap; wb_t fin; logic [1:0] after; bit hung, varied; exp_t e;
    tbl = '{'{4'd0,  32'h0000_1234, 32'd5,  0, 32'h0000_1234, 4'h0},
            '{4'd12, 32'hDEAD_BEEF, 32'd31, 0, 32'hDEAD_BEEF, 4'h0},
            '{4'd9,  32'h0000_0042, 32'd2,  0, 32'h0000_0042, 4'h0}};
    foreach (tbl[i]) begin
      e.wb = '{tbl[i].data[4:0], (i != 2), tbl[i].res, 1'b0, 1'b0};
      e.stalls = 0; e.reqs = 0; e.bus = '0;
      sb.push_back(e);
      run_op(tbl[i].op, 32'h0000_0101, 32'h0, tbl[i].addr, tbl[i].data[4:0], (i != 2),
             32'h0, 0, 1'b0, stalls, reqs, snap, fin, after, hung, varied);
      e = sb.pop_front();
      total++;
      if (fin !== e.wb) begin bad++; $display("[TB] FAIL alu%0d_wb: got %h want %h", i, fin, e.wb); end
      total++;
      if ({stalls, reqs} !== {e.stalls, e.reqs} || hung) begin
        bad++; $display("[TB] FAIL alu%0d_stall: got stalls=%0d reqs=%0d want 0/0", i, stalls, reqs);
      end
    end
  endtask

  task automatic test_loads();
    case_t tbl[7];
    int stalls, reqs; busv_t snap; wb_t fin; logic [1:0] after; bit hung, varied; exp_t e;
    tbl = '{'{4'd1, 32'h0000_0101, 32'h11F0_3344, 2, 32'hFFFF_FFF0, 4'b0100},
            '{4'd2, 32'h0000_0101, 32'h11F0_3344, 2, 32'h0000_00F0, 4'b0100},
            '{4'd3, 32'h0000_0100, 32'h8001_7777, 0, 32'hFFFF_8001, 4'b1100},
            '{4'd4, 32'h0000_0102, 32'h1234_F00D, 1, 32'h0000_F00D, 4'b0011},
            '{4'd5, 32'h0000_0200, 32'hCAFE_BABE, 0, 32'hCAFE_BABE, 4'b1111},
            '{4'd1, 32'h0000_0003, 32'hAAAA_AA7F, 0, 32'h0000_007F, 4'b0001},
            '{4'd1, 32'h0000_0000, 32'h80FF_FFFF, 3, 32'hFFFF_FF80, 4'b1000}};
    foreach (tbl[i]) begin
      e.wb = '{5'd7, 1'b1, tbl[i].res, 1'b0, 1'b0};
      e.stalls = tbl[i].delay + 1;
      e.reqs = tbl[i].delay + 1;
      e.bus = '{1'b0, {tbl[i].addr[31:2], 2'b00}, tbl[i].sel, 32'h0};
      sb.push_back(e);
      run_op(tbl[i].op, tbl[i].addr, 32'h0, tbl[i].addr, 5'd7, 1'b1, tbl[i].data,
             tbl[i].delay, 1'b1, stalls, reqs, snap, fin, after, hung, varied);
      e = sb.pop_front();
      total++;
      if (fin !== e.wb) begin bad++; $display("[TB] FAIL load%0d_wb: got %h want %h", i, fin, e.wb); end
      total++;
      if (snap !== e.bus || varied) begin
        bad++; $display("[TB] FAIL load%0d_bus: got %h want %h varied=%0d", i, snap, e.bus, varied);
      end
      total++;
      if (stalls != e.stalls || reqs != e.reqs || hung || after !== 2'b00) begin
        bad++; $display("[TB] FAIL load%0d_timing: got stalls=%0d reqs=%0d want %0d/%0d", i, stalls, reqs, e.stalls, e.reqs);
      end
    end
  endtask

  task automatic test_stores();
    case_t tbl[4];
    int stalls, reqs; busv_t snap; wb_t fin; logic [1:0] after; bit hung, varied; exp_t e;
    tbl = '{'{4'd7, 32'h0000_0102, 32'hABCD_1234, 0, 32'h1234_1234, 4'b0011},
            '{4'd6, 32'h0000_0103, 32'h0000_005A, 1, 32'h5A5A_5A5A, 4'b0001},
            '{4'd6, 32'h0000_0100, 32'h1234_56C3, 0, 32'hC3C3_C3C3, 4'b1000},
            '{4'd8, 32'h0000_0104, 32'h0102_0304, 2, 32'h0102_0304, 4'b1111}};
    foreach (tbl[i]) begin
      e.wb = '{5'd0, 1'b0, tbl[i].addr, 1'b0, 1'b0};
      e.stalls = tbl[i].delay + 1;
      e.reqs = tbl[i].delay + 1;
      e.bus = '{1'b1, {tbl[i].addr[31:2], 2'b00}, tbl[i].sel, tbl[i].res};
      sb.push_back(e);
      run_op(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].addr, 5'd0, 1'b0, 32'hFFFF_FFFF,
             tbl[i].delay, 1'b1, stalls, reqs, snap, fin, after, hung, varied);
      e = sb.pop_front();
      total++;
      if (snap !== e.bus || varied) begin
        bad++; $display("[TB] FAIL store%0d_bus: got %h want %h varied=%0d", i, snap, e.bus, varied);
      end
      total++;
      if (fin !== e.wb || stalls != e.stalls || hung) begin
        bad++; $display("[TB] FAIL store%0d_wb: got %h stalls=%0d want %h stalls=%0d", i, fin, stalls, e.wb, e.stalls);
      end
    end
  endtask

  task automatic test_misaligned();
    case_t tbl[5];
    int stalls, reqs; busv_t snap; wb_t fin; logic [1:0] after; bit hung, varied; exp_t e;
    tbl = '{'{4'd5, 32'h0000_0006, 32'h0, 0, 32'h0, 4'h0},
            '{4'd3, 32'h0000_0101, 32'h0, 0, 32'h0, 4'h0},
            '{4'd4, 32'h0000_0001, 32'h0, 0, 32'h0, 4'h0},
            '{4'd7, 32'h0000_0103, 32'h0, 0, 32'h0, 4'h0},
            '{4'd8, 32'h0000_0102, 32'h0, 0, 32'h0, 4'h0}};
    foreach (tbl[i]) begin
      e.wb = '{5'd0, 1'b0, 32'h0, 1'b1, 1'b0};
      e.stalls = 0; e.reqs = 0; e.bus = '0;
      sb.push_back(e);
      run_op(tbl[i].op, tbl[i].addr, 32'hFFFF_FFFF, 32'h5555_5555, 5'd3, 1'b1, 32'h0,
             0, 1'b1, stalls, reqs, snap, fin, after, hung, varied);
      e = sb.pop_front();
      total++;
      if (fin !== e.wb) begin bad++; $display("[TB] FAIL align%0d_wb: got %h want %h", i, fin, e.wb); end
      total++;
      if (stalls != 0 || reqs != 0 || hung || after !== 2'b00) begin
        bad++; $display("[TB] FAIL align%0d_pulse: got stalls=%0d reqs=%0d after=%b want 0/0/00", i, stalls, reqs, after);
      end
    end
  endtask

  task automatic test_timeout();
    int stalls, reqs; busv_t snap; wb_t fin; logic [1:0] after; bit hung, varied; exp_t e;
    e.wb = '{5'd0, 1'b0, 32'h0, 1'b0, 1'b1};
    e.stalls = TO; e.reqs = TO; e.bus = '{1'b0, 32'h10, 4'b1111, 32'h0};
    sb.push_back(e);
    run_op(4'd5, 32'h10, 32'h0, 32'h10, 5'd9, 1'b1, 32'h0, -1, 1'b1,
           stalls, reqs, snap, fin, after, hung, varied);
    e = sb.pop_front();
    total++;
    if (fin !== e.wb || after !== 2'b00) begin
      bad++; $display("[TB] FAIL timeout_wb: got %h after=%b want %h after=00", fin, after, e.wb);
    end
    total++;
    if (stalls != e.stalls || reqs != e.reqs || hung || varied) begin
      bad++; $display("[TB] FAIL timeout_len: got stalls=%0d reqs=%0d want %0d/%0d", stalls, reqs, e.stalls, e.reqs);
    end
    total++;
    if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL timeout_req: got %b want 0", bus_req); end
    e.wb = '{5'd9, 1'b1, 32'h7777_0000, 1'b0, 1'b0};
    e.stalls = TO; e.reqs = TO;
    sb.push_back(e);
    run_op(4'd5, 32'h20, 32'h0, 32'h20, 5'd9, 1'b1, 32'h7777_0000, TO - 1, 1'b1,
           stalls, reqs, snap, fin, after, hung, varied);
    e = sb.pop_front();
    total++;
    if (fin !== e.wb || after !== 2'b00 || stalls != e.stalls || reqs != e.reqs || hung) begin
      bad++; $display("[TB] FAIL late_ack: got %h stalls=%0d reqs=%0d want %h %0d/%0d", fin, stalls, reqs, e.wb, e.stalls, e.reqs);
    end
  endtask

  task automatic test_back_to_back();
    int stalls, reqs; busv_t snap; wb_t fin; logic [1:0] after; bit hung, varied; exp_t e;
    e.wb = '{5'd4, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0}; e.stalls = 2; e.reqs = 2; e.bus = '0;
    sb.push_back(e);
    e.wb = '{5'd6, 1'b1, 32'h0000_00BA, 1'b0, 1'b0}; e.stalls = 1; e.reqs = 1;
    sb.push_back(e);
    e.wb = '{5'd8, 1'b1, 32'h0000_0077, 1'b0, 1'b0}; e.stalls = 0; e.reqs = 0;
    sb.push_back(e);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: run_op(4'd5, 32'h300, 32'h0, 32'h300, 5'd4, 1'b1, 32'h0BAD_F00D, 1, 1'b0,
                  stalls, reqs, snap, fin, after, hung, varied);
        1: run_op(4'd2, 32'h302, 32'h0, 32'h302, 5'd6, 1'b1, 32'h0000_BA00, 0, 1'b0,
                  stalls, reqs, snap, fin, after, hung, varied);
        default: run_op(4'd0, 32'h0, 32'h0, 32'h77, 5'd8, 1'b1, 32'h0, 0, 1'b1,
                        stalls, reqs, snap, fin, after, hung, varied);
      endcase
      e = sb.pop_front();
      total++;
      if (fin !== e.wb || stalls != e.stalls || reqs != e.reqs || hung) begin
        bad++; $display("[TB] FAIL b2b%0d: got %h stalls=%0d reqs=%0d want %h %0d/%0d", k, fin, stalls, reqs, e.wb, e.stalls, e.reqs);
      end
    end
  endtask

  task automatic test_reset_mid_bus();
    int seen;
    mem_op = 4'd5; mem_addr = 32'h40; mem_wd = 5'd12; mem_wreg = 1'b1; mem_wdata = 32'h40;
    bus_ack = 1'b0; bus_rdata = 32'h1357_9BDF;
    step();
    step();
    total++;
    if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_start: got bus_req=%b want 1", bus_req); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus_req, bus_we, bus_sel} !== 6'b0) begin
      bad++; $display("[TB] FAIL rst_async: got req/we/sel=%b want 0", {bus_req, bus_we, bus_sel});
    end
    mem_op = 4'd0; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
    step();
    rst = 1'b1;
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (wb_wreg !== 1'b0 || bus_err !== 1'b0 || bus_req !== 1'b0 || exc_align !== 1'b0) seen++;
      step();
    end
    total++;
    if (seen != 0) begin bad++; $display("[TB] FAIL rst_no_completion: got %0d bad cycles want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
    mem_op = 4'd0; mem_addr = 32'h0; mem_sdata = 32'h0; mem_wdata = 32'h0;
    mem_wd = 5'd0; mem_wreg = 1'b0;
    test_reset();
    test_alu_pass();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, max cycles spent in BUS waiting for bus_ack before abort.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 mem_wd / mem_wreg / mem_wdata  in  5/1/32  destination reg, write enable, ALU result from the EX/MEM register.
REQ-005 mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-006 mem_addr / mem_sdata  in  32/32  effective byte address, store data (low bits used for SB/SH).
REQ-007 bus_req / bus_we  out  1/1  data-bus request, write strobe.
REQ-008 bus_addr / bus_sel / bus_wdata  out  32/4/32  word address ({addr[31:2],2'b00}), big-endian byte lanes, write data.
REQ-009 bus_rdata / bus_ack  in  32/1  read data, completion strobe.
REQ-010 stall_req  out  1  combinational; upstream holds all mem_* inputs stable while high.
REQ-011 wb_wd / wb_wreg / wb_wdata  out  5/1/32  registered result toward MEM/WB.
REQ-012 exc_align / bus_err  out  1/1  registered one-cycle pulses: misaligned access, bus timeout.

Function
REQ-013 States: IDLE, BUS; the FSM changes state only on rising clk edges.
REQ-014 IDLE, mem_op none: next edge wb_* <= mem_*; no stall, no bus activity.
REQ-015 Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; no bus access, stall_req=0, next edge exc_align=1, wb_wreg=0, wb_wd=0, wb_wdata=0.
REQ-016 IDLE, aligned mem op: stall_req=1; next edge registers bus_req=1, bus_we, bus_addr, bus_sel, bus_wdata, clears timeout counter, enters BUS; wb_wreg=0 (bubble).
REQ-017 bus_sel: byte ops addr[1:0]=0..3 -> 1000,0100,0010,0001; half ops addr[1]=0 -> 1100, else 0011; word -> 1111.
REQ-018 bus_wdata: SB replicates sdata[7:0] in all four lanes; SH replicates sdata[15:0] in both halves; SW = sdata.
REQ-019 BUS: bus_req and all bus_* held constant until ack or timeout; stall_req = !bus_ack.
REQ-020 BUS with bus_ack=1: next edge bus_req=0, state IDLE, wb_wd=mem_wd, wb_wreg=mem_wreg, wb_wdata=load result (loads) or mem_wdata (stores).
REQ-021 Load result: selected byte/half from bus_rdata lanes per REQ-017; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-022 Timeout counter increments each BUS cycle without ack; at count ACK_TIMEOUT-1 without ack: stall_req=0, next edge bus_req=0, IDLE, bus_err=1, wb_wreg=0.
REQ-023 bus_ack in IDLE ignored; ack coincident with the timeout cycle counts as success (no bus_err).
REQ-024 The cycle after completion returns to IDLE and evaluates the new upstream instruction; the same access never reissues.
REQ-025 exc_align and bus_err are high for exactly one cycle per event.

Reset
REQ-026 rst=0 forces immediately, regardless of clk: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, wb_wd=0, wb_wreg=0, wb_wdata=0, exc_align=0, bus_err=0, counter=0.
REQ-027 Reset asserted during BUS abandons the transaction; no completion, error or writeback follows after release.

Verification
REQ-028 ALU pass: op=0, wd=5, wreg=1, wdata=0x1234 -> next cycle wb_wd=5, wb_wreg=1, wb_wdata=0x1234, stall_req low throughout.
REQ-029 LB addr=0x101, ack after 2 wait cycles with rdata=0x11_F0_33_44 -> bus_sel=0100, stall 3 cycles, wb_wdata=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-030 SH addr=0x102, sdata=0xABCD1234 -> bus_we=1, bus_addr=0x100, bus_sel=0011, bus_wdata=0x12341234, wb_wreg=0 after ack.
REQ-031 LW addr=0x6 -> no bus_req, exc_align pulse 1 cycle, wb_wreg=0, stall_req never high.
REQ-032 LW, no ack, ACK_TIMEOUT=16 -> bus_req held 16 cycles then dropped, bus_err 1 cycle, wb_wreg=0, stall released.
REQ-033 rst low mid-BUS -> bus_req 0 same cycle; after release, late ack ignored, no writeback.
